// File: rtl/mac2ibuff_pkg.sv
// Shared types and helpers for the MAC rx -> rx_ibuff ring writer.
package mac2ibuff_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RCV,
    COMMIT,
    DROP
  } state_t;

  // Header word layout: byte length in the low bits, rest zero.
  localparam int unsigned HDR_LEN_LSB = 0;
  localparam int unsigned HDR_LEN_W   = 16;

  // Number of valid bytes in a beat given its byte-enable mask.
  function automatic logic [3:0] valid2cnt(input logic [7:0] mask);
    logic [3:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, mask[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/mac2ibuff.sv
// Writes MAC rx frames into the rx ring as [length header][payload...],
// publishing the producer pointer only once a frame is known good.
module mac2ibuff
  import mac2ibuff_pkg::*;
#(
  parameter int unsigned BW           = 9,
  parameter int unsigned MAX_FRAME_QW = 190
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [63:0]   rx_data,
  input  logic [7:0]    rx_data_valid,
  input  logic          rx_good_frame,
  input  logic          rx_bad_frame,
  output logic [BW-1:0] wr_addr,
  output logic [63:0]   wr_data,
  output logic          wr_en,
  output logic [BW:0]   committed_prod,
  input  logic [BW:0]   committed_cons,
  output logic [31:0]   dropped_frames
);

  localparam int unsigned PW = BW + 1;

  state_t          state, state_nxt;
  logic [PW-1:0]   wp, wp_nxt, prod_nxt;
  logic [15:0]     qw_cnt, qw_nxt, byte_cnt, byte_nxt;
  logic            drop_cnted, drop_cnted_nxt;
  logic            wr_en_nxt;
  logic [BW-1:0]   wr_addr_nxt;
  logic [63:0]     wr_data_nxt;
  logic            count_drop;

  logic [PW-1:0]   used;
  logic [PW:0]     free;
  logic            has_room;
  logic            beat, end_good, end_bad, end_any;
  logic [15:0]     beat_bytes;
  logic [PW-1:0]   hdr_p1, hdr_p2, wp_p1, commit_ptr;

  // The header slot is always committed_prod: an aborted frame rewinds simply
  // by never moving it.
  assign used       = committed_prod - committed_cons;
  assign free       = (PW+1)'(2 ** BW) - {1'b0, used};
  assign has_room   = free >= (PW+1)'(MAX_FRAME_QW + 1);
  assign beat       = |rx_data_valid;
  assign end_bad    = rx_bad_frame;
  assign end_good   = rx_good_frame & ~rx_bad_frame;
  assign end_any    = rx_good_frame | rx_bad_frame;
  assign beat_bytes = {12'h000, valid2cnt(rx_data_valid)};
  assign hdr_p1     = committed_prod + PW'(1);
  assign hdr_p2     = committed_prod + PW'(2);
  assign wp_p1      = wp + PW'(1);
  assign commit_ptr = committed_prod + PW'(1) + qw_cnt[PW-1:0];

  // Next-state, next-output and bookkeeping for the frame FSM.
  always_comb begin
    state_nxt      = state;
    wp_nxt         = wp;
    qw_nxt         = qw_cnt;
    byte_nxt       = byte_cnt;
    prod_nxt       = committed_prod;
    drop_cnted_nxt = drop_cnted;
    count_drop     = 1'b0;
    wr_en_nxt      = 1'b0;
    wr_addr_nxt    = wr_addr;
    wr_data_nxt    = wr_data;

    unique case (state)
      IDLE: begin
        drop_cnted_nxt = 1'b0;
        if (beat) begin
          if (has_room) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = hdr_p1[BW-1:0];
            wr_data_nxt = rx_data;
            wp_nxt      = hdr_p2;
            qw_nxt      = 16'd1;
            byte_nxt    = beat_bytes;
            if (end_bad) begin
              count_drop = 1'b1;
            end else if (end_good) begin
              state_nxt = COMMIT;
            end else begin
              state_nxt = RCV;
            end
          end else if (end_any) begin
            count_drop = 1'b1;
          end else begin
            state_nxt = DROP;
          end
        end
      end

      RCV: begin
        if (beat && (qw_cnt >= 16'(MAX_FRAME_QW))) begin
          if (end_any) begin
            count_drop = 1'b1;
            state_nxt  = IDLE;
          end else begin
            state_nxt = DROP;
          end
        end else begin
          if (beat) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = wp[BW-1:0];
            wr_data_nxt = rx_data;
            wp_nxt      = wp_p1;
            qw_nxt      = qw_cnt + 16'd1;
            byte_nxt    = byte_cnt + beat_bytes;
          end
          if (end_bad) begin
            count_drop = 1'b1;
            state_nxt  = IDLE;
          end else if (end_good) begin
            state_nxt = COMMIT;
          end
        end
      end

      COMMIT: begin
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = committed_prod[BW-1:0];
        wr_data_nxt = 64'(byte_cnt) << HDR_LEN_LSB;
        prod_nxt    = commit_ptr;
        state_nxt   = IDLE;
        // A beat here starts a frame we cannot take; it is counted now, so
        // DROP must not count it again when its end pulse arrives.
        if (beat) begin
          count_drop = 1'b1;
          if (!end_any) begin
            state_nxt      = DROP;
            drop_cnted_nxt = 1'b1;
          end
        end
      end

      DROP: begin
        if (end_any) begin
          count_drop = ~drop_cnted;
          state_nxt  = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Registered state and outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      wp             <= '0;
      qw_cnt         <= '0;
      byte_cnt       <= '0;
      drop_cnted     <= 1'b0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      committed_prod <= '0;
      dropped_frames <= '0;
    end else begin
      state          <= state_nxt;
      wp             <= wp_nxt;
      qw_cnt         <= qw_nxt;
      byte_cnt       <= byte_nxt;
      drop_cnted     <= drop_cnted_nxt;
      wr_en          <= wr_en_nxt;
      wr_addr        <= wr_addr_nxt;
      wr_data        <= wr_data_nxt;
      committed_prod <= prod_nxt;
      if (count_drop && (dropped_frames != '1)) begin
        dropped_frames <= dropped_frames + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mac2ibuff.sv
// Self-checking bench for mac2ibuff: random frames against a ring/pointer model.
module tb_mac2ibuff;

  localparam int BW    = 9;
  localparam int MAXQ  = 190;
  localparam int DEPTH = 512;
  localparam int PMOD  = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [63:0]   rx_data = '0;
  logic [7:0]    rx_data_valid = '0;
  logic          rx_good_frame = 1'b0;
  logic          rx_bad_frame = 1'b0;
  logic [BW-1:0] wr_addr;
  logic [63:0]   wr_data;
  logic          wr_en;
  logic [BW:0]   committed_prod;
  logic [BW:0]   committed_cons = '0;
  logic [31:0]   dropped_frames;

  int checks = 0;
  int failures = 0;

  // What the DUT actually wrote into the ring, and how many writes it made.
  logic [63:0] ring [DEPTH];
  int          wr_count = 0;

  // Reference model: pointer, drop count and expected ring image.
  int unsigned m_prod = 0;
  int unsigned m_drop = 0;
  logic [63:0] m_ring [DEPTH];
  logic [63:0] fdata [$];
  bit          m_committed;
  int unsigned m_hdr, m_len;

  mac2ibuff #(.BW(BW), .MAX_FRAME_QW(MAXQ)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data        (rx_data),
    .rx_data_valid  (rx_data_valid),
    .rx_good_frame  (rx_good_frame),
    .rx_bad_frame   (rx_bad_frame),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .committed_prod (committed_prod),
    .committed_cons (committed_cons),
    .dropped_frames (dropped_frames)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      ring[wr_addr] <= wr_data;
      wr_count      <= wr_count + 1;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [8:0] idx(input int unsigned a);
    return 9'(a % DEPTH);
  endfunction

  function automatic logic [7:0] mask_of(input int k);
    logic [7:0] m;
    m = 8'hFF;
    return m >> (8 - k);
  endfunction

  // Drive one frame. mode: 0 good with last beat, 1 good after, 2 bad with
  // last, 3 bad after, 4 good+bad with last. tail=0 leaves the bus on its
  // last beat so another frame can follow immediately.
  task automatic send_frame(input int n, input int k, input int mode, input bit tail);
    fdata.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_data       = {$urandom, $urandom};
      fdata.push_back(rx_data);
      rx_data_valid = (i == n - 1) ? mask_of(k) : 8'hFF;
      rx_good_frame = (i == n - 1) && (mode == 0 || mode == 4);
      rx_bad_frame  = (i == n - 1) && (mode == 2 || mode == 4);
    end
    if (tail) begin
      @(negedge clk);
      rx_data_valid = '0;
      rx_data       = '0;
      rx_good_frame = (mode == 1);
      rx_bad_frame  = (mode == 3);
      @(negedge clk);
      rx_good_frame = 1'b0;
      rx_bad_frame  = 1'b0;
    end
  endtask

  task automatic idle_bus(input int cycles);
    @(negedge clk);
    rx_data_valid = '0;
    rx_data       = '0;
    rx_good_frame = 1'b0;
    rx_bad_frame  = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  // Frame-level rules: accepted only with room for a maximum frame at the
  // start, at most MAXQ words, and a clean good ending.
  task automatic model_frame(input int n, input int k, input int mode);
    int unsigned used, free;
    used = (m_prod + PMOD - int'(committed_cons)) % PMOD;
    free = DEPTH - used;
    m_committed = 1'b0;
    if (free >= MAXQ + 1 && n <= MAXQ && (mode == 0 || mode == 1)) begin
      m_hdr = m_prod;
      m_len = n;
      m_ring[idx(m_prod)] = 64'(8 * (n - 1) + k);
      for (int i = 0; i < n; i++) m_ring[idx(m_prod + 1 + i)] = fdata[i];
      m_prod = (m_prod + 1 + n) % PMOD;
      m_committed = 1'b1;
    end else begin
      m_drop++;
    end
  endtask

  task automatic run_frame(input int n, input int k, input int mode);
    send_frame(n, k, mode, 1'b1);
    model_frame(n, k, mode);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%0h exp=0", wr_en); end
    checks++; if (wr_addr !== '0) begin failures++; $display("FAIL reset_wr_addr got=%0h exp=0", wr_addr); end
    checks++; if (wr_data !== '0) begin failures++; $display("FAIL reset_wr_data got=%0h exp=0", wr_data); end
    checks++; if (committed_prod !== '0) begin failures++; $display("FAIL reset_prod got=%0h exp=0", committed_prod); end
    checks++; if (dropped_frames !== '0) begin failures++; $display("FAIL reset_dropped got=%0h exp=0", dropped_frames); end
    rst = 1'b1;
    m_prod = 0;
    m_drop = 0;
    @(negedge clk);
  endtask

  task automatic test_basic_64;
    int wc0, bad;
    committed_cons = '0;
    wc0 = wr_count;
    run_frame(8, 8, 0);
    checks++; if (committed_prod !== 10'd9) begin failures++; $display("FAIL basic_prod got=%0h exp=9", committed_prod); end
    checks++; if (wr_count - wc0 != 9) begin failures++; $display("FAIL basic_writes got=%0d exp=9", wr_count - wc0); end
    checks++; if (ring[0] !== 64'h40) begin failures++; $display("FAIL basic_header got=%0h exp=40", ring[0]); end
    bad = 0;
    for (int i = 0; i < 8; i++) if (ring[i + 1] !== fdata[i]) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL basic_payload got=%0d_bad_words exp=0", bad); end
    checks++; if (dropped_frames !== 32'd0) begin failures++; $display("FAIL basic_dropped got=%0d exp=0", dropped_frames); end
  endtask

  task automatic test_good_after;
    int unsigned hdr;
    hdr = m_prod;
    committed_cons = 10'(m_prod);
    run_frame(8, 5, 1);
    checks++; if (ring[idx(hdr)] !== 64'h3D) begin failures++; $display("FAIL after_header got=%0h exp=3d", ring[idx(hdr)]); end
    checks++; if (committed_prod !== 10'((hdr + 9) % PMOD)) begin failures++; $display("FAIL after_prod got=%0h exp=%0h", committed_prod, (hdr + 9) % PMOD); end
  endtask

  task automatic test_bad_overwrite;
    int unsigned hdr;
    int wc0, bad;
    hdr = m_prod;
    wc0 = wr_count;
    run_frame(5, 8, 3);
    checks++; if (wr_count - wc0 != 5) begin failures++; $display("FAIL bad_writes got=%0d exp=5", wr_count - wc0); end
    checks++; if (committed_prod !== 10'(hdr)) begin failures++; $display("FAIL bad_prod got=%0h exp=%0h", committed_prod, hdr); end
    checks++; if (dropped_frames !== 32'(m_drop)) begin failures++; $display("FAIL bad_dropped got=%0d exp=%0d", dropped_frames, m_drop); end
    run_frame(6, 8, 0);
    bad = 0;
    for (int i = 0; i < 6; i++) if (ring[idx(hdr + 1 + i)] !== fdata[i]) bad++;
    checks++; if (bad != 0 || ring[idx(hdr)] !== 64'd48) begin failures++; $display("FAIL overwrite_frame got=%0d_bad_hdr_%0h exp=0_bad_hdr_30", bad, ring[idx(hdr)]); end
    checks++; if (committed_prod !== 10'((hdr + 7) % PMOD)) begin failures++; $display("FAIL overwrite_prod got=%0h exp=%0h", committed_prod, (hdr + 7) % PMOD); end
  endtask

  task automatic test_precedence_and_zero;
    int unsigned hdr;
    int wc0;
    hdr = m_prod;
    run_frame(3, 8, 4);
    checks++; if (dropped_frames !== 32'(m_drop) || committed_prod !== 10'(hdr)) begin failures++; $display("FAIL both_pulses got=%0d/%0h exp=%0d/%0h", dropped_frames, committed_prod, m_drop, hdr); end
    wc0 = wr_count;
    @(negedge clk); rx_good_frame = 1'b1;
    @(negedge clk); rx_good_frame = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wr_count != wc0 || dropped_frames !== 32'(m_drop) || committed_prod !== 10'(hdr)) begin failures++; $display("FAIL zero_len got=%0d/%0d/%0h exp=0/%0d/%0h", wr_count - wc0, dropped_frames, committed_prod, m_drop, hdr); end
  endtask

  task automatic test_commit_collision;
    int bad;
    committed_cons = 10'(m_prod);
    send_frame(3, 8, 0, 1'b0);
    model_frame(3, 8, 0);
    send_frame(2, 8, 0, 1'b0);
    m_drop++;
    idle_bus(4);
    checks++; if (committed_prod !== 10'(m_prod)) begin failures++; $display("FAIL collide_prod got=%0h exp=%0h", committed_prod, m_prod); end
    checks++; if (dropped_frames !== 32'(m_drop)) begin failures++; $display("FAIL collide_dropped got=%0d exp=%0d", dropped_frames, m_drop); end
    bad = 0;
    for (int unsigned i = 0; i <= m_len; i++) if (ring[idx(m_hdr + i)] !== m_ring[idx(m_hdr + i)]) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL collide_frame got=%0d_bad_words exp=0", bad); end
  endtask

  task automatic test_wrap;
    int rem, n, bad;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_prod = 0;
    m_drop = 0;
    rem = 508;
    while (rem > 0) begin
      n = (rem <= MAXQ + 1) ? rem - 1 : ((rem == MAXQ + 2) ? 100 : MAXQ);
      committed_cons = 10'(m_prod);
      run_frame(n, 8, 0);
      rem -= n + 1;
    end
    checks++; if (committed_prod !== 10'h1FC) begin failures++; $display("FAIL wrap_setup got=%0h exp=1fc", committed_prod); end
    committed_cons = 10'h1FC;
    run_frame(4, 8, 0);
    checks++; if (ring[9'h1FC] !== 64'd32) begin failures++; $display("FAIL wrap_header got=%0h exp=20", ring[9'h1FC]); end
    bad = 0;
    if (ring[9'h1FD] !== fdata[0]) bad++;
    if (ring[9'h1FE] !== fdata[1]) bad++;
    if (ring[9'h1FF] !== fdata[2]) bad++;
    if (ring[9'h000] !== fdata[3]) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL wrap_payload got=%0d_bad_words exp=0", bad); end
    checks++; if (committed_prod !== 10'h201) begin failures++; $display("FAIL wrap_prod got=%0h exp=201", committed_prod); end
  endtask

  task automatic test_space;
    int unsigned hdr;
    int wc0;
    hdr = m_prod;
    committed_cons = 10'((m_prod + PMOD - (DEPTH - 100)) % PMOD);
    wc0 = wr_count;
    run_frame(4, 8, 0);
    checks++; if (wr_count != wc0) begin failures++; $display("FAIL full_writes got=%0d exp=0", wr_count - wc0); end
    checks++; if (dropped_frames !== 32'(m_drop) || committed_prod !== 10'(hdr)) begin failures++; $display("FAIL full_drop got=%0d/%0h exp=%0d/%0h", dropped_frames, committed_prod, m_drop, hdr); end
    committed_cons = committed_cons + 10'd200;
    run_frame(4, 8, 0);
    checks++; if (committed_prod !== 10'((hdr + 5) % PMOD)) begin failures++; $display("FAIL room_accept got=%0h exp=%0h", committed_prod, (hdr + 5) % PMOD); end
  endtask

  task automatic test_oversize;
    int unsigned hdr;
    int wc0;
    hdr = m_prod;
    committed_cons = 10'(m_prod);
    wc0 = wr_count;
    run_frame(200, 8, 1);
    checks++; if (wr_count - wc0 != MAXQ) begin failures++; $display("FAIL oversize_writes got=%0d exp=%0d", wr_count - wc0, MAXQ); end
    checks++; if (committed_prod !== 10'(hdr) || dropped_frames !== 32'(m_drop)) begin failures++; $display("FAIL oversize_drop got=%0h/%0d exp=%0h/%0d", committed_prod, dropped_frames, hdr, m_drop); end
  endtask

  task automatic test_random;
    int n, k, mode, bad;
    for (int it = 0; it < 24; it++) begin
      committed_cons = 10'((m_prod + PMOD - $urandom_range(0, 340)) % PMOD);
      n    = $urandom_range(1, 24);
      k    = $urandom_range(1, 8);
      mode = $urandom_range(0, 4);
      run_frame(n, k, mode);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++; if (committed_prod !== 10'(m_prod) || dropped_frames !== 32'(m_drop)) begin failures++; $display("FAIL random_%0d_ptrs got=%0h/%0d exp=%0h/%0d", it, committed_prod, dropped_frames, m_prod, m_drop); end
      if (m_committed) begin
        bad = 0;
        for (int unsigned i = 0; i <= m_len; i++) if (ring[idx(m_hdr + i)] !== m_ring[idx(m_hdr + i)]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL random_%0d_frame got=%0d_bad_words exp=0", it, bad); end
      end
    end
  endtask

  task automatic test_reset_midframe;
    committed_cons = 10'(m_prod);
    send_frame(3, 8, 0, 1'b0);
    rx_good_frame = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rx_data_valid = '0;
    @(negedge clk);
    checks++; if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0) begin failures++; $display("FAIL midreset_wr got=%0h/%0h/%0h exp=0/0/0", wr_en, wr_addr, wr_data); end
    checks++; if (committed_prod !== '0 || dropped_frames !== '0) begin failures++; $display("FAIL midreset_ptrs got=%0h/%0d exp=0/0", committed_prod, dropped_frames); end
    rst = 1'b1;
    m_prod = 0;
    m_drop = 0;
    committed_cons = '0;
    run_frame(2, 3, 0);
    checks++; if (committed_prod !== 10'd3 || ring[0] !== 64'd11) begin failures++; $display("FAIL post_reset got=%0h/%0h exp=3/b", committed_prod, ring[0]); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ring[i]   = '0;
      m_ring[i] = '0;
    end
    test_reset;
    test_basic_64;
    test_good_after;
    test_bad_overwrite;
    test_precedence_and_zero;
    test_commit_collision;
    test_oversize;
    test_wrap;
    test_space;
    test_random;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
